// File: rtl/key_select_ctrl_if.sv
// Button inputs and highlight/status outputs of the key selection controller.
// The board side uses master, the controller uses slave.
interface key_select_ctrl_if #(
    parameter int NUM_KEYS = 12
);
    logic                        btn_next;
    logic                        btn_prev;
    logic                        btn_mode;
    logic [NUM_KEYS-1:0]         keySelect;
    logic [$clog2(NUM_KEYS)-1:0] root_idx;
    logic [1:0]                  chord_mode;
    logic                        sel_changed;

    modport master (
        output btn_next, btn_prev, btn_mode,
        input  keySelect, root_idx, chord_mode, sel_changed
    );

    modport slave (
        input  btn_next, btn_prev, btn_mode,
        output keySelect, root_idx, chord_mode, sel_changed
    );
endinterface

// File: rtl/key_select_ctrl.sv
// Debounced button control of the chord root and mode, expanded into a
// registered multi-key highlight vector for the VGA key renderer.
module key_select_ctrl #(
    parameter int NUM_KEYS        = 12,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAJ_THIRD       = 4,
    parameter int MIN_THIRD       = 3,
    parameter int FIFTH           = 7
) (
    input  logic             ClkPort,
    input  logic             Reset_n,
    key_select_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_KEYS);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int B_NEXT = 0;
    localparam int B_PREV = 1;
    localparam int B_MODE = 2;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_MAJOR  = 2'd1,
        MODE_MINOR  = 2'd2
    } mode_e;

    logic [2:0]          raw_s;
    logic [2:0]          sync1_r;
    logic [2:0]          sync2_r;
    logic [2:0]          db_r;
    logic [2:0]          db_d_r;
    logic [2:0]          press_r;
    logic [CW-1:0]       cnt_r [3];

    mode_e               mode_r;
    mode_e               mode_next_s;
    logic [IW-1:0]       root_r;
    logic [IW-1:0]       root_next_s;
    logic [NUM_KEYS-1:0] key_r;
    logic [NUM_KEYS-1:0] key_next_s;
    logic                sel_r;

    // (a + off) mod NUM_KEYS without a divider; a is always below NUM_KEYS
    function automatic logic [IW-1:0] mod_add(input logic [IW-1:0] a, input int unsigned off);
        logic [IW:0] sum;
        sum = {1'b0, a} + (IW+1)'(off);
        if (sum >= (IW+1)'(NUM_KEYS)) begin
            sum = sum - (IW+1)'(NUM_KEYS);
        end else begin
            sum = sum;
        end
        return sum[IW-1:0];
    endfunction

    function automatic logic [NUM_KEYS-1:0] expand(input logic [IW-1:0] root, input mode_e mode);
        logic [NUM_KEYS-1:0] vec;
        vec       = {NUM_KEYS{1'b0}};
        vec[root] = 1'b1;
        case (mode)
            MODE_MAJOR: begin
                vec[mod_add(root, MAJ_THIRD)] = 1'b1;
                vec[mod_add(root, FIFTH)]     = 1'b1;
            end
            MODE_MINOR: begin
                vec[mod_add(root, MIN_THIRD)] = 1'b1;
                vec[mod_add(root, FIFTH)]     = 1'b1;
            end
            default: vec = vec;
        endcase
        return vec;
    endfunction

    assign raw_s = {bus.btn_mode, bus.btn_prev, bus.btn_next};

    // Synchronise, debounce and edge-detect each button
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            db_r    <= 3'b000;
            db_d_r  <= 3'b000;
            press_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            db_d_r  <= db_r;
            press_r <= db_r & ~db_d_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] != db_r[i]) begin
                    if (cnt_r[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db_r[i]  <= ~db_r[i];
                        cnt_r[i] <= {CW{1'b0}};
                    end else begin
                        cnt_r[i] <= cnt_r[i] + CW'(1);
                    end
                end else begin
                    cnt_r[i] <= {CW{1'b0}};
                end
            end
        end
    end

    // Root stepping; opposing presses in the same cycle cancel
    always_comb begin
        root_next_s = root_r;
        if (press_r[B_NEXT] && !press_r[B_PREV]) begin
            root_next_s = (root_r == IW'(NUM_KEYS - 1)) ? {IW{1'b0}} : root_r + IW'(1);
        end else if (press_r[B_PREV] && !press_r[B_NEXT]) begin
            root_next_s = (root_r == {IW{1'b0}}) ? IW'(NUM_KEYS - 1) : root_r - IW'(1);
        end else begin
            root_next_s = root_r;
        end
    end

    // Chord mode next state; the unused encoding falls back to SINGLE
    always_comb begin
        mode_next_s = mode_r;
        case (mode_r)
            MODE_SINGLE: mode_next_s = press_r[B_MODE] ? MODE_MAJOR  : MODE_SINGLE;
            MODE_MAJOR:  mode_next_s = press_r[B_MODE] ? MODE_MINOR  : MODE_MAJOR;
            MODE_MINOR:  mode_next_s = press_r[B_MODE] ? MODE_SINGLE : MODE_MINOR;
            default:     mode_next_s = press_r[B_MODE] ? MODE_MAJOR  : MODE_SINGLE;
        endcase
    end

    assign key_next_s = expand(root_next_s, mode_next_s);

    // Selection state and change pulse, all updated on the same edge
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_r <= MODE_SINGLE;
            root_r <= {IW{1'b0}};
            key_r  <= {{(NUM_KEYS-1){1'b0}}, 1'b1};
            sel_r  <= 1'b0;
        end else begin
            mode_r <= mode_next_s;
            root_r <= root_next_s;
            key_r  <= key_next_s;
            sel_r  <= (key_next_s != key_r);
        end
    end

    assign bus.keySelect   = key_r;
    assign bus.root_idx    = root_r;
    assign bus.chord_mode  = mode_r;
    assign bus.sel_changed = sel_r;
endmodule

// File: tb/tb_key_select_ctrl.sv
// Directed bench for key_select_ctrl with a scoreboard of expected selections
// popped on every sel_changed pulse.
module tb_key_select_ctrl;
    localparam int NK = 12;
    localparam int DC = 4;

    logic ClkPort = 1'b0;
    logic Reset_n = 1'b0;

    key_select_ctrl_if #(.NUM_KEYS(NK)) bus ();

    key_select_ctrl #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC),
        .MAJ_THIRD(4), .MIN_THIRD(3), .FIFTH(7)
    ) dut (
        .ClkPort(ClkPort),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    always #5 ClkPort = ~ClkPort;

    int errors = 0;
    int checks = 0;
    int sel_count = 0;
    int root_m = 0;
    int mode_m = 0;
    int snap;
    logic [17:0] exp_q [$];

    function automatic logic [11:0] model_key(input int r, input int m);
        logic [11:0] v;
        v = 12'h000;
        v[r] = 1'b1;
        if (m == 1) begin
            v[(r + 4) % 12] = 1'b1;
            v[(r + 7) % 12] = 1'b1;
        end else if (m == 2) begin
            v[(r + 3) % 12] = 1'b1;
            v[(r + 7) % 12] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [17:0] pack_model();
        return {model_key(root_m, mode_m), 4'(root_m), 2'(mode_m)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_key"},  32'(bus.keySelect),  32'(model_key(root_m, mode_m)));
        check({tag, "_root"}, 32'(bus.root_idx),   32'(root_m));
        check({tag, "_mode"}, 32'(bus.chord_mode), 32'(mode_m));
    endtask

    // Scoreboard: each change pulse must match the oldest pending expectation
    always @(negedge ClkPort) begin
        if (Reset_n && bus.sel_changed) begin
            sel_count++;
            check("sel_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("scoreboard", 32'({bus.keySelect, bus.root_idx, bus.chord_mode}),
                      32'(exp_q.pop_front()));
            end
        end
    end

    task automatic press(input logic n, input logic p, input logic m, input int hold);
        logic [11:0] old_key;
        old_key = model_key(root_m, mode_m);
        if (n && !p) root_m = (root_m == 11) ? 0 : root_m + 1;
        else if (p && !n) root_m = (root_m == 0) ? 11 : root_m - 1;
        if (m) mode_m = (mode_m == 2) ? 0 : mode_m + 1;
        if (model_key(root_m, mode_m) != old_key) exp_q.push_back(pack_model());
        @(negedge ClkPort);
        bus.btn_next = n;
        bus.btn_prev = p;
        bus.btn_mode = m;
        repeat (hold) @(negedge ClkPort);
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        bus.btn_mode = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge ClkPort);
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (12) @(negedge ClkPort);
        check_state("press");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        bus.btn_mode = 1'b0;
        Reset_n = 1'b0;
        repeat (3) @(negedge ClkPort);
        check("rst_key",  32'(bus.keySelect),   32'h001);
        check("rst_root", 32'(bus.root_idx),    32'd0);
        check("rst_mode", 32'(bus.chord_mode),  32'd0);
        check("rst_sel",  32'(bus.sel_changed), 32'd0);
        Reset_n = 1'b1;
        repeat (5) @(negedge ClkPort);
        check_state("idle");
        check("idle_sel", 32'(bus.sel_changed), 32'd0);

        // Held next: exact latency and a single step
        root_m = 1;
        exp_q.push_back(pack_model());
        bus.btn_next = 1'b1;
        repeat (7) @(posedge ClkPort);
        @(negedge ClkPort);
        check("lat_edge7_root", 32'(bus.root_idx),    32'd0);
        check("lat_edge7_sel",  32'(bus.sel_changed), 32'd0);
        @(posedge ClkPort);
        @(negedge ClkPort);
        check("lat_edge8_root", 32'(bus.root_idx),    32'd1);
        check("lat_edge8_key",  32'(bus.keySelect),   32'h002);
        check("lat_edge8_sel",  32'(bus.sel_changed), 32'd1);
        @(negedge ClkPort);
        check("pulse_width", 32'(bus.sel_changed), 32'd0);
        repeat (11) @(negedge ClkPort);
        bus.btn_next = 1'b0;
        repeat (15) @(negedge ClkPort);
        check("hold_drain", 32'(exp_q.size()), 32'd0);
        check("hold_one_step", 32'(sel_count), 32'd1);
        check_state("hold");

        // Wrap forward then backward
        for (int k = 0; k < 11; k++) press(1'b1, 1'b0, 1'b0, 8);
        check("next_wrap_root", 32'(bus.root_idx), 32'd0);
        press(1'b0, 1'b1, 1'b0, 8);
        check("prev_wrap_root", 32'(bus.root_idx),  32'd11);
        check("prev_wrap_key",  32'(bus.keySelect), 32'h800);

        // Mode cycle at root 0
        press(1'b1, 1'b0, 1'b0, 8);
        press(1'b0, 1'b0, 1'b1, 8);
        check("major_key", 32'(bus.keySelect), 32'h091);
        press(1'b0, 1'b0, 1'b1, 8);
        check("minor_key", 32'(bus.keySelect), 32'h089);
        press(1'b0, 1'b0, 1'b1, 8);
        check("single_key", 32'(bus.keySelect), 32'h001);

        // MAJOR at root 9 wraps the chord tones
        for (int k = 0; k < 3; k++) press(1'b0, 1'b1, 1'b0, 8);
        press(1'b0, 1'b0, 1'b1, 8);
        check("major9_key", 32'(bus.keySelect), 32'h212);

        snap = sel_count;
        press(1'b1, 1'b1, 1'b0, 8);
        check("collide_nopulse", 32'(sel_count), 32'(snap));
        check("collide_root", 32'(bus.root_idx), 32'd9);

        // Mode and root together land in one update
        press(1'b1, 1'b0, 1'b1, 8);
        check("combo_key", 32'(bus.keySelect), 32'h422);

        // Short glitch is rejected
        snap = sel_count;
        @(negedge ClkPort);
        bus.btn_next = 1'b1;
        repeat (3) @(negedge ClkPort);
        bus.btn_next = 1'b0;
        repeat (20) @(negedge ClkPort);
        check("glitch_nopulse", 32'(sel_count), 32'(snap));
        check_state("glitch");

        // Reset in the middle of a mode debounce
        bus.btn_mode = 1'b1;
        repeat (4) @(negedge ClkPort);
        Reset_n = 1'b0;
        #1;
        check("midrst_key",  32'(bus.keySelect),   32'h001);
        check("midrst_root", 32'(bus.root_idx),    32'd0);
        check("midrst_mode", 32'(bus.chord_mode),  32'd0);
        check("midrst_sel",  32'(bus.sel_changed), 32'd0);
        bus.btn_mode = 1'b0;
        root_m = 0;
        mode_m = 0;
        repeat (3) @(negedge ClkPort);
        Reset_n = 1'b1;
        snap = sel_count;
        repeat (20) @(negedge ClkPort);
        check("midrst_nopulse", 32'(sel_count), 32'(snap));
        check_state("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
